// File: rtl/hdc_am_pkg.sv
// Shared types and width helpers for the folded multiclass associative memory.
// Optional reject output is enabled by defining AM_REJECT_EN.
`ifndef HV_DIMENSION
`define HV_DIMENSION 2000
`endif
`ifndef AM_NUM_FOLDS
`define AM_NUM_FOLDS 10
`endif

package hdc_am_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StSearch,
      StDone
   } am_state_e;

   localparam logic RejectCode = 1'b1;

   // Never returns 0 so that single-entry indices still get a 1-bit port.
   function automatic int unsigned ceil_log2(int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int unsigned class_width(int unsigned num_classes);
      return ceil_log2(num_classes);
   endfunction

   function automatic int unsigned dist_width(int unsigned hv_dimension);
      return ceil_log2(hv_dimension + 1);
   endfunction

endpackage

// File: rtl/associative_memory_multiclass_fold_popcount.sv
// Combinational population count over one fold of the query/prototype XOR.
module fold_popcount #(
   parameter int unsigned Width    = 200,
   parameter int unsigned CntWidth = 8
) (
   input  logic [Width-1:0]    data_i,
   output logic [CntWidth-1:0] count_o
);

   always_comb begin
      count_o = '0;
      for (int unsigned i = 0; i < Width; i++) begin
         count_o = count_o + CntWidth'(data_i[i]);
      end
   end

endmodule

// File: rtl/associative_memory_multiclass.sv
// Fold-serial Hamming nearest-class search over programmable prototypes.
// Define AM_REJECT_EN to add the distance-threshold reject output.
`ifndef HV_DIMENSION
`define HV_DIMENSION 2000
`endif
`ifndef AM_NUM_FOLDS
`define AM_NUM_FOLDS 10
`endif

module associative_memory_multiclass
   import hdc_am_pkg::*;
#(
   parameter int unsigned HV_DIMENSION       = `HV_DIMENSION,
   parameter int unsigned AM_NUM_FOLDS       = `AM_NUM_FOLDS,
   parameter int unsigned NUM_CLASSES        = 10,
   parameter int unsigned AM_FOLD_WIDTH      = HV_DIMENSION / AM_NUM_FOLDS,
   parameter int unsigned CLASS_WIDTH        = class_width(NUM_CLASSES),
   parameter int unsigned DIST_WIDTH         = dist_width(HV_DIMENSION),
   parameter int unsigned AM_NUM_FOLDS_WIDTH = ceil_log2(AM_NUM_FOLDS)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          hvin_valid,
   output logic                          hvin_ready,
   input  logic [HV_DIMENSION-1:0]       hvin,
   input  logic                          proto_we,
   output logic                          proto_ready,
   input  logic [CLASS_WIDTH-1:0]        proto_class,
   input  logic [AM_NUM_FOLDS_WIDTH-1:0] proto_fold,
   input  logic [AM_FOLD_WIDTH-1:0]      proto_data,
   output logic                          dout_valid,
   input  logic                          dout_ready,
   output logic [CLASS_WIDTH-1:0]        keyword,
   output logic [DIST_WIDTH-1:0]         distance
`ifdef AM_REJECT_EN
   ,
   input  logic [DIST_WIDTH-1:0]         reject_threshold,
   output logic [0:0]                    reject
`endif
);

   am_state_e                   state_q, state_d;
   logic [HV_DIMENSION-1:0]     hvin_q, hvin_d;
   logic [CLASS_WIDTH-1:0]      cls_q, cls_d, best_cls_q, best_cls_d, keyword_q, keyword_d;
   logic [AM_NUM_FOLDS_WIDTH-1:0] fold_q, fold_d;
   logic [DIST_WIDTH-1:0]       acc_q, acc_d, best_q, best_d, distance_q, distance_d;
   logic                        dout_valid_q, dout_valid_d;
   logic [DIST_WIDTH-1:0]       pop_cnt, fold_sum;
   logic [AM_FOLD_WIDTH-1:0]    mem_q [NUM_CLASSES][AM_NUM_FOLDS];
   logic                        idle_rdy, accept, last_fold, last_class, better;
`ifdef AM_REJECT_EN
   logic [DIST_WIDTH-1:0]       thresh_q, thresh_d;
   logic                        reject_q, reject_d;
`endif

   assign idle_rdy   = (state_q == StIdle) && !rst;
   assign accept     = hvin_valid && idle_rdy;
   assign last_fold  = (fold_q == AM_NUM_FOLDS_WIDTH'(AM_NUM_FOLDS - 1));
   assign last_class = (cls_q == CLASS_WIDTH'(NUM_CLASSES - 1));

   // Prototype store; writes only land while idle and for valid indices.
   always_ff @(posedge clk) begin
      if (proto_we && idle_rdy && (32'(proto_class) < NUM_CLASSES)
          && (32'(proto_fold) < AM_NUM_FOLDS)) begin
         mem_q[proto_class][proto_fold] <= proto_data;
      end
   end

   fold_popcount #(
      .Width    (AM_FOLD_WIDTH),
      .CntWidth (DIST_WIDTH)
   ) u_fold_popcount (
      .data_i  (hvin_q[fold_q * AM_FOLD_WIDTH +: AM_FOLD_WIDTH] ^ mem_q[cls_q][fold_q]),
      .count_o (pop_cnt)
   );

   assign fold_sum = acc_q + pop_cnt;
   // Strict compare keeps the lowest class index on ties.
   assign better   = (fold_sum < best_q);

   always_ff @(posedge clk) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (accept) state_d = StSearch;
         StSearch: if (last_fold && last_class) state_d = StDone;
         StDone:   if (dout_ready) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      hvin_ready  = idle_rdy;
      proto_ready = idle_rdy;
      dout_valid  = dout_valid_q;
      keyword     = keyword_q;
      distance    = distance_q;
`ifdef AM_REJECT_EN
      reject      = reject_q;
`endif
   end

   always_comb begin
      hvin_d       = hvin_q;
      cls_d        = cls_q;
      fold_d       = fold_q;
      acc_d        = acc_q;
      best_d       = best_q;
      best_cls_d   = best_cls_q;
      keyword_d    = keyword_q;
      distance_d   = distance_q;
      dout_valid_d = dout_valid_q;
`ifdef AM_REJECT_EN
      thresh_d     = thresh_q;
      reject_d     = reject_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               hvin_d     = hvin;
               cls_d      = '0;
               fold_d     = '0;
               acc_d      = '0;
               best_d     = '1;
               best_cls_d = '0;
`ifdef AM_REJECT_EN
               thresh_d   = reject_threshold;
`endif
            end
         end
         StSearch: begin
            if (last_fold) begin
               acc_d  = '0;
               fold_d = '0;
               cls_d  = last_class ? '0 : cls_q + 1'b1;
               if (better) begin
                  best_d     = fold_sum;
                  best_cls_d = cls_q;
               end
               if (last_class) begin
                  keyword_d    = best_cls_d;
                  distance_d   = best_d;
                  dout_valid_d = 1'b1;
`ifdef AM_REJECT_EN
                  reject_d     = (best_d > thresh_q) ? RejectCode : ~RejectCode;
`endif
               end
            end else begin
               acc_d  = fold_sum;
               fold_d = fold_q + 1'b1;
            end
         end
         StDone: begin
            if (dout_ready) begin
               dout_valid_d = 1'b0;
`ifdef AM_REJECT_EN
               reject_d     = 1'b0;
`endif
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hvin_q       <= '0;
         cls_q        <= '0;
         fold_q       <= '0;
         acc_q        <= '0;
         best_q       <= '0;
         best_cls_q   <= '0;
         keyword_q    <= '0;
         distance_q   <= '0;
         dout_valid_q <= 1'b0;
`ifdef AM_REJECT_EN
         thresh_q     <= '0;
         reject_q     <= 1'b0;
`endif
      end else begin
         hvin_q       <= hvin_d;
         cls_q        <= cls_d;
         fold_q       <= fold_d;
         acc_q        <= acc_d;
         best_q       <= best_d;
         best_cls_q   <= best_cls_d;
         keyword_q    <= keyword_d;
         distance_q   <= distance_d;
         dout_valid_q <= dout_valid_d;
`ifdef AM_REJECT_EN
         thresh_q     <= thresh_d;
         reject_q     <= reject_d;
`endif
      end
   end

endmodule

// File: tb/tb_associative_memory_multiclass.sv
// Scoreboard bench for associative_memory_multiclass at default parameters.
module tb_associative_memory_multiclass;

   localparam int HV = 2000;
   localparam int NF = 10;
   localparam int NC = 10;
   localparam int FW = 200;
   localparam int CW = 4;
   localparam int DW = 11;
   localparam int FOW = 4;

   typedef struct {
      logic [CW-1:0] k;
      logic [DW-1:0] d;
      logic          r;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          hvin_valid, hvin_ready, proto_we, proto_ready, dout_valid, dout_ready;
   logic [HV-1:0] hvin;
   logic [CW-1:0] proto_class, keyword;
   logic [FOW-1:0] proto_fold;
   logic [FW-1:0] proto_data;
   logic [DW-1:0] distance;
`ifdef AM_REJECT_EN
   logic [DW-1:0] reject_threshold;
   logic [0:0]    reject;
`endif

   int   n_cmp = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   t_acc;
   exp_t exp_q[$];
   logic [HV-1:0] rnd_proto [NC];

   associative_memory_multiclass dut (
      .clk         (clk),
      .rst         (rst),
      .hvin_valid  (hvin_valid),
      .hvin_ready  (hvin_ready),
      .hvin        (hvin),
      .proto_we    (proto_we),
      .proto_ready (proto_ready),
      .proto_class (proto_class),
      .proto_fold  (proto_fold),
      .proto_data  (proto_data),
      .dout_valid  (dout_valid),
      .dout_ready  (dout_ready),
      .keyword     (keyword),
      .distance    (distance)
`ifdef AM_REJECT_EN
      ,
      .reject_threshold (reject_threshold),
      .reject           (reject)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, expv);
      end
   endtask

   // Monitor: pops the scoreboard on every result handshake.
   always @(negedge clk) begin
      if (rst === 1'b0 && dout_valid === 1'b1 && dout_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_result: keyword=%0d distance=%0d", keyword, distance);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("keyword", 64'(keyword), 64'(e.k));
            check("distance", 64'(distance), 64'(e.d));
`ifdef AM_REJECT_EN
            check("reject", 64'(reject), 64'(e.r));
`endif
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [HV-1:0] ones_low(input int n);
      logic [HV-1:0] v;
      v = '0;
      for (int i = 0; i < n; i++) v[i] = 1'b1;
      return v;
   endfunction

   task automatic write_fold(input int c, input int f, input logic [FW-1:0] d);
      proto_we    = 1'b1;
      proto_class = CW'(c);
      proto_fold  = FOW'(f);
      proto_data  = d;
      tick();
      proto_we    = 1'b0;
   endtask

   task automatic load_proto(input int c, input logic [HV-1:0] v);
      for (int f = 0; f < NF; f++) write_fold(c, f, v[f*FW +: FW]);
   endtask

   task automatic start_query(input logic [HV-1:0] q, input int thr, input bit push,
                              input int k, input int d, input bit r);
      int n;
      exp_t e;
      n = 0;
      while (hvin_ready !== 1'b1 && n < 300) begin
         tick();
         n++;
      end
      check("hvin_ready_wait", 64'(hvin_ready), 64'd1);
      hvin_valid = 1'b1;
      hvin       = q;
`ifdef AM_REJECT_EN
      reject_threshold = DW'(thr);
`else
      n = thr;
`endif
      if (push) begin
         e.k = CW'(k);
         e.d = DW'(d);
         e.r = r;
         exp_q.push_back(e);
      end
      tick();
      t_acc      = cyc;
      hvin_valid = 1'b0;
      hvin       = {63{$urandom()}};  // garbage while busy must be ignored
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (dout_valid !== 1'b1 && n < 300) begin
         tick();
         n++;
      end
      check("latency", 64'(cyc - t_acc), 64'd100);
   endtask

   initial begin
      logic [2047:0] big;
      logic [CW-1:0] k0;
      logic [DW-1:0] d0;
      rst = 1'b1;
      hvin_valid = 1'b0;
      hvin = '0;
      proto_we = 1'b0;
      proto_class = '0;
      proto_fold = '0;
      proto_data = '0;
      dout_ready = 1'b1;
`ifdef AM_REJECT_EN
      reject_threshold = '0;
`endif
      tick();
      check("ready_in_reset", 64'(hvin_ready), 64'd0);
      check("proto_ready_in_reset", 64'(proto_ready), 64'd0);
      tick();
      rst = 1'b0;
      #1;
      check("reset_dout_valid", 64'(dout_valid), 64'd0);
      check("reset_keyword", 64'(keyword), 64'd0);
      check("reset_distance", 64'(distance), 64'd0);
      check("reset_hvin_ready", 64'(hvin_ready), 64'd1);

      // Exact match against random prototypes
      for (int c = 0; c < NC; c++) begin
         for (int i = 0; i < 64; i++) big[i*32 +: 32] = $urandom();
         rnd_proto[c] = big[HV-1:0];
         load_proto(c, rnd_proto[c]);
      end
      start_query(rnd_proto[3], 2047, 1'b1, 3, 0, 1'b0);
      wait_done();
      tick();

      // Tie: classes 2 and 5 at 200, others 300+10c, query all zeros
      for (int c = 0; c < NC; c++)
         load_proto(c, ones_low((c == 2 || c == 5) ? 200 : 300 + 10 * c));
      start_query('0, 2047, 1'b1, 2, 200, 1'b0);
      wait_done();
      tick();

      // Backpressure for 20 cycles
      dout_ready = 1'b0;
      start_query('0, 2047, 1'b1, 2, 200, 1'b0);
      wait_done();
      k0 = keyword;
      d0 = distance;
      for (int i = 0; i < 20; i++) begin
         check("bp_valid", 64'(dout_valid), 64'd1);
         check("bp_keyword", 64'(keyword), 64'(k0));
         check("bp_distance", 64'(distance), 64'(d0));
         check("bp_hvin_ready", 64'(hvin_ready), 64'd0);
         tick();
      end
      dout_ready = 1'b1;
      tick();
      check("post_hs_hvin_ready", 64'(hvin_ready), 64'd1);
      check("post_hs_valid", 64'(dout_valid), 64'd0);

      // Write gating: dropped during search, applied in idle
      start_query('0, 2047, 1'b1, 2, 200, 1'b0);
      repeat (5) tick();
      proto_we    = 1'b1;
      proto_class = 4'd0;
      proto_fold  = 4'd0;
      proto_data  = '0;
      check("search_proto_ready", 64'(proto_ready), 64'd0);
      tick();
      proto_we = 1'b0;
      wait_done();
      tick();
      write_fold(0, 0, '0);
      start_query('0, 2047, 1'b1, 0, 100, 1'b0);
      wait_done();
      tick();

      // Reset in search cycle 50
      start_query('0, 2047, 1'b0, 0, 0, 1'b0);
      repeat (49) tick();
      rst = 1'b1;
      #1;
      check("mid_rst_hvin_ready", 64'(hvin_ready), 64'd0);
      tick();
      rst = 1'b0;
      #1;
      check("abort_dout_valid", 64'(dout_valid), 64'd0);
      check("abort_keyword", 64'(keyword), 64'd0);
      check("abort_distance", 64'(distance), 64'd0);
      check("abort_hvin_ready", 64'(hvin_ready), 64'd1);
      start_query('0, 2047, 1'b1, 0, 100, 1'b0);
      wait_done();
      tick();

`ifdef AM_REJECT_EN
      // Reject threshold: argmin class 4 at 1000
      for (int c = 0; c < NC; c++) load_proto(c, ones_low((c == 4) ? 1000 : 1100 + 10 * c));
      start_query('0, 400, 1'b1, 4, 1000, 1'b1);
      wait_done();
      tick();
      start_query('0, 1500, 1'b1, 4, 1000, 1'b0);
      wait_done();
      tick();
`endif

      repeat (3) tick();
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
